// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses,
// mstatus/mie/mip bit positions and the trap cause codes.
package csr_file_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;

    // Same positions serve mie and mip.
    localparam int MIX_SW_BIT    = 3;
    localparam int MIX_TIMER_BIT = 7;
    localparam int MIX_EXT_BIT   = 11;

    localparam logic [3:0] MCAUSE_INSN_MISALIGNED  = 4'd0;
    localparam logic [3:0] MCAUSE_INSN_ACCESS      = 4'd1;
    localparam logic [3:0] MCAUSE_ILLEGAL_INSN     = 4'd2;
    localparam logic [3:0] MCAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] MCAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] MCAUSE_LOAD_ACCESS      = 4'd5;
    localparam logic [3:0] MCAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] MCAUSE_STORE_ACCESS     = 4'd7;
    localparam logic [3:0] MCAUSE_ECALL_M          = 4'd11;
    localparam logic [3:0] MCAUSE_IRQ_SW           = 4'd3;
    localparam logic [3:0] MCAUSE_IRQ_TIMER        = 4'd7;
    localparam logic [3:0] MCAUSE_IRQ_EXT          = 4'd11;

    // Reserved MODE encodings (2, 3) collapse to direct mode.
    function automatic logic [31:0] mtvec_legalize(input logic [31:0] d);
        return d[1] ? {d[31:2], 2'b00} : d;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit wrapping counter with increment enable and per-half software writes.
// A write to either half suppresses the increment for that cycle.
module csr_counter64 (
    input  logic        ck_i,
    input  logic        rs_n_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wr_d_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i)
            cnt_d = {cnt_q[63:32], wr_d_i};
        else if (wr_hi_i)
            cnt_d = {wr_d_i, cnt_q[31:0]};
        else if (inc_i)
            cnt_d = cnt_q + 64'd1;
    end

    always_ff @(posedge ck_i or negedge rs_n_i) begin
        if (!rs_n_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core: one read port, one write port,
// trap-sequencer update strobes and synchronised interrupt lines.
// Counters (mcycle/minstret) exist only when CSR_COUNTERS_EN is defined.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        ck_i,
    input  logic        rs_n_i,
    input  logic [11:0] rd_a_i,
    output logic [31:0] rd_d_o,
    input  logic        we_i,
    input  logic [11:0] wr_a_i,
    input  logic [31:0] wr_d_i,
    output logic        illegal_o,
    input  logic        ie_type_i,
    input  logic        set_cause_i,
    input  logic [3:0]  trap_cause_i,
    input  logic        set_epc_i,
    input  logic [31:0] epc_i,
    input  logic        set_mtval_i,
    input  logic [31:0] mtval_i,
    input  logic        mstatus_ie_clear_i,
    input  logic        mstatus_ie_set_i,
    input  logic        irq_external_i,
    input  logic        irq_timer_i,
    input  logic        irq_software_i,
    input  logic        instret_i,
    output logic        mstatus_ie_o,
    output logic        mie_external_o,
    output logic        mie_timer_o,
    output logic        mie_sw_o,
    output logic        mip_external_o,
    output logic        mip_timer_o,
    output logic        mip_sw_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] epc_o
);

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [2:0]  mie_en_q, mie_en_d;   // {MEIE, MTIE, MSIE}
    logic [2:0]  mip_q;                // {MEIP, MTIP, MSIP}
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic        mcause_irq_q, mcause_irq_d;
    logic [3:0]  mcause_code_q, mcause_code_d;
    logic [31:0] mtval_q, mtval_d;

    logic        rd_impl, wr_impl, wr_ro;
    logic [31:0] rd_data;
    logic        wr_en;

    logic [2:0]  unused_bits;
    assign unused_bits = {epc_i[1:0], instret_i};

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;

    csr_counter64 u_mcycle (
        .ck_i    (ck_i),
        .rs_n_i  (rs_n_i),
        .inc_i   (1'b1),
        .wr_lo_i (wr_en && wr_a_i == CSR_MCYCLE),
        .wr_hi_i (wr_en && wr_a_i == CSR_MCYCLEH),
        .wr_d_i  (wr_d_i),
        .cnt_o   (mcycle)
    );

    csr_counter64 u_minstret (
        .ck_i    (ck_i),
        .rs_n_i  (rs_n_i),
        .inc_i   (instret_i),
        .wr_lo_i (wr_en && wr_a_i == CSR_MINSTRET),
        .wr_hi_i (wr_en && wr_a_i == CSR_MINSTRETH),
        .wr_d_i  (wr_d_i),
        .cnt_o   (minstret)
    );
`endif

    // Read mux: unimplemented addresses return 0.
    always_comb begin
        rd_data = '0;
        rd_impl = 1'b1;
        case (rd_a_i)
            CSR_MSTATUS: begin
                rd_data[MSTATUS_MIE_BIT]                   = mie_q;
                rd_data[MSTATUS_MPIE_BIT]                  = mpie_q;
                rd_data[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB] = 2'b11;
            end
            CSR_MISA:     rd_data = MISA_VAL;
            CSR_MIE: begin
                rd_data[MIX_EXT_BIT]   = mie_en_q[2];
                rd_data[MIX_TIMER_BIT] = mie_en_q[1];
                rd_data[MIX_SW_BIT]    = mie_en_q[0];
            end
            CSR_MTVEC:    rd_data = mtvec_q;
            CSR_MSCRATCH: rd_data = mscratch_q;
            CSR_MEPC:     rd_data = mepc_q;
            CSR_MCAUSE:   rd_data = {mcause_irq_q, 27'd0, mcause_code_q};
            CSR_MTVAL:    rd_data = mtval_q;
            CSR_MIP: begin
                rd_data[MIX_EXT_BIT]   = mip_q[2];
                rd_data[MIX_TIMER_BIT] = mip_q[1];
                rd_data[MIX_SW_BIT]    = mip_q[0];
            end
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    rd_data = mcycle[31:0];
            CSR_MCYCLEH:   rd_data = mcycle[63:32];
            CSR_MINSTRET:  rd_data = minstret[31:0];
            CSR_MINSTRETH: rd_data = minstret[63:32];
`endif
            CSR_MHARTID:  rd_data = HART_ID;
            default:      rd_impl = 1'b0;
        endcase
    end

    always_comb begin
        wr_impl = 1'b1;
        wr_ro   = 1'b0;
        case (wr_a_i)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL: wr_ro = 1'b0;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE, CSR_MCYCLEH,
            CSR_MINSTRET, CSR_MINSTRETH:     wr_ro = 1'b0;
`endif
            CSR_MISA, CSR_MIP, CSR_MHARTID:  wr_ro = 1'b1;
            default:                         wr_impl = 1'b0;
        endcase
    end

    assign wr_en     = we_i && wr_impl && !wr_ro;
    assign illegal_o = !rd_impl || (we_i && (!wr_impl || wr_ro));
    assign rd_d_o    = rd_data;

    // Software writes first; trap-sequencer updates override the same register.
    always_comb begin
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        mie_en_d      = mie_en_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_irq_d  = mcause_irq_q;
        mcause_code_d = mcause_code_q;
        mtval_d       = mtval_q;

        if (wr_en) begin
            case (wr_a_i)
                CSR_MSTATUS: begin
                    mie_d  = wr_d_i[MSTATUS_MIE_BIT];
                    mpie_d = wr_d_i[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_en_d = {wr_d_i[MIX_EXT_BIT], wr_d_i[MIX_TIMER_BIT],
                                          wr_d_i[MIX_SW_BIT]};
                CSR_MTVEC:    mtvec_d = mtvec_legalize(wr_d_i);
                CSR_MSCRATCH: mscratch_d = wr_d_i;
                CSR_MEPC:     mepc_d = {wr_d_i[31:2], 2'b00};
                CSR_MCAUSE: begin
                    mcause_irq_d  = wr_d_i[31];
                    mcause_code_d = wr_d_i[3:0];
                end
                CSR_MTVAL:    mtval_d = wr_d_i;
                default: ;
            endcase
        end

        if (mstatus_ie_clear_i) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end else if (mstatus_ie_set_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        if (set_cause_i) begin
            mcause_irq_d  = ie_type_i;
            mcause_code_d = trap_cause_i;
            if (set_mtval_i) mtval_d = mtval_i;
        end

        if (set_epc_i) mepc_d = {epc_i[31:2], 2'b00};
    end

    always_ff @(posedge ck_i or negedge rs_n_i) begin
        if (!rs_n_i) begin
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            mie_en_q      <= '0;
            mip_q         <= '0;
            mtvec_q       <= MTVEC_RESET;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_irq_q  <= 1'b0;
            mcause_code_q <= '0;
            mtval_q       <= '0;
        end else begin
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            mie_en_q      <= mie_en_d;
            mip_q         <= {irq_external_i, irq_timer_i, irq_software_i};
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_irq_q  <= mcause_irq_d;
            mcause_code_q <= mcause_code_d;
            mtval_q       <= mtval_d;
        end
    end

    assign mstatus_ie_o   = mie_q;
    assign mie_external_o = mie_en_q[2];
    assign mie_timer_o    = mie_en_q[1];
    assign mie_sw_o       = mie_en_q[0];
    assign mip_external_o = mip_q[2];
    assign mip_timer_o    = mip_q[1];
    assign mip_sw_o       = mip_q[0];
    assign mtvec_o        = mtvec_q;
    assign epc_o          = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; counter checks follow CSR_COUNTERS_EN.
module tb_csr_file;

    localparam logic [31:0] HART     = 32'd3;
    localparam logic [31:0] MISA     = 32'h4000_0100;
    localparam logic [31:0] MTVEC_RV = 32'h1000_0040;

    logic        ck = 1'b0, rs_n = 1'b0;
    logic [11:0] rd_a = '0, wr_a = '0;
    logic [31:0] rd_d, wr_d = '0, epc = '0, mtval = '0, mtvec, epc_o;
    logic        we = 0, illegal, ie_type = 0, set_cause = 0, set_epc = 0, set_mtval = 0;
    logic [3:0]  cause = '0;
    logic        ie_clr = 0, ie_set = 0, irq_e = 0, irq_t = 0, irq_s = 0, instret = 0;
    logic        mstatus_ie, mie_e, mie_t, mie_s, mip_e, mip_t, mip_s;

    int n_chk = 0, n_pass = 0;

    always #5 ck = ~ck;

    csr_file #(.HART_ID(HART), .MISA_VAL(MISA), .MTVEC_RESET(MTVEC_RV)) dut (
        .ck_i(ck), .rs_n_i(rs_n), .rd_a_i(rd_a), .rd_d_o(rd_d),
        .we_i(we), .wr_a_i(wr_a), .wr_d_i(wr_d), .illegal_o(illegal),
        .ie_type_i(ie_type), .set_cause_i(set_cause), .trap_cause_i(cause),
        .set_epc_i(set_epc), .epc_i(epc), .set_mtval_i(set_mtval), .mtval_i(mtval),
        .mstatus_ie_clear_i(ie_clr), .mstatus_ie_set_i(ie_set),
        .irq_external_i(irq_e), .irq_timer_i(irq_t), .irq_software_i(irq_s),
        .instret_i(instret), .mstatus_ie_o(mstatus_ie),
        .mie_external_o(mie_e), .mie_timer_o(mie_t), .mie_sw_o(mie_s),
        .mip_external_o(mip_e), .mip_timer_o(mip_t), .mip_sw_o(mip_s),
        .mtvec_o(mtvec), .epc_o(epc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        we = 1'b1; wr_a = a; wr_d = d;
        step();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        rd_a = a;
        #1;
        chk(tag, rd_d, exp);
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, mstatus_ie, mie_e, mie_t, mie_s, mip_e, mip_t, mip_s};
    endfunction

    initial begin
        repeat (2) @(negedge ck);
        rs_n = 1'b1;
        @(negedge ck);
        chk("rst_outs", outs(), 32'd0);
        chk("rst_mtvec", mtvec, MTVEC_RV);
        chk("rst_epc", epc_o, 32'd0);
        rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
        chk("rst_rd_legal", {31'd0, illegal}, 32'd0);

        // Mid-run asynchronous reset
        csr_wr(12'h304, 32'h888);
        csr_wr(12'h300, 32'h8);
        csr_wr(12'h305, 32'h8000_0003);
        chk("mie_set_outs", outs(), 32'h78);
        chk("mtvec_mode_fix", mtvec, 32'h8000_0000);
        irq_t = 1'b1;
        step();
        #2 rs_n = 1'b0;
        #1;
        chk("async_rst_outs", outs(), 32'd0);
        chk("async_rst_mtvec", mtvec, MTVEC_RV);
        irq_t = 1'b0;
        @(negedge ck);
        rs_n = 1'b1;
        rd_chk("post_rst_mie", 12'h304, 32'd0);

        // Trap entry then return
        csr_wr(12'h300, 32'h8);
        chk("mie_before_trap", {31'd0, mstatus_ie}, 32'd1);
        set_cause = 1; ie_type = 1; cause = 4'd11; set_epc = 1; epc = 32'h106; ie_clr = 1;
        step();
        set_cause = 0; ie_type = 0; cause = 0; set_epc = 0; ie_clr = 0;
        rd_chk("trap_mcause", 12'h342, 32'h8000_000B);
        chk("trap_epc", epc_o, 32'h104);
        rd_chk("trap_mstatus", 12'h300, 32'h0000_1880);
        chk("trap_mie_o", {31'd0, mstatus_ie}, 32'd0);
        ie_set = 1;
        step();
        ie_set = 0;
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);
        ie_clr = 1; ie_set = 1;
        step();
        ie_clr = 0; ie_set = 0;
        rd_chk("clr_wins", 12'h300, 32'h0000_1880);

        // Trap update vs software write collisions
        we = 1; wr_a = 12'h341; wr_d = 32'h2000; set_epc = 1; epc = 32'h100;
        step();
        we = 0; set_epc = 0;
        chk("coll_same_reg", epc_o, 32'h100);
        csr_wr(12'h341, 32'h3001);
        chk("mepc_align", epc_o, 32'h3000);
        we = 1; wr_a = 12'h340; wr_d = 32'h2000; set_epc = 1; epc = 32'h100;
        step();
        we = 0; set_epc = 0;
        rd_chk("coll_mscratch", 12'h340, 32'h2000);
        chk("coll_other_epc", epc_o, 32'h100);

        // mtval qualifier
        set_mtval = 1; mtval = 32'hDEAD;
        step();
        rd_chk("mtval_no_cause", 12'h343, 32'd0);
        set_cause = 1; cause = 4'd2;
        step();
        set_cause = 0; set_mtval = 0;
        rd_chk("mtval_cause", 12'h343, 32'hDEAD);
        rd_chk("mcause_exc", 12'h342, 32'h0000_0002);

        // Illegal / read-only accesses
        rd_a = 12'h300; we = 1; wr_a = 12'h344; wr_d = 32'hFFF;
        #1;
        chk("wr_mip_illegal", {31'd0, illegal}, 32'd1);
        step();
        we = 0;
        rd_chk("mip_unchanged", 12'h344, 32'd0);
        chk("ro_legal_idle", {31'd0, illegal}, 32'd0);
        rd_chk("rd_unimpl", 12'h7C0, 32'd0);
        chk("rd_unimpl_ill", {31'd0, illegal}, 32'd1);
        rd_chk("misa", 12'h301, MISA);
        rd_chk("mhartid", 12'hF14, HART);
        rd_a = 12'h300; we = 1; wr_a = 12'hF14; wr_d = 32'h5;
        #1;
        chk("wr_hartid_ill", {31'd0, illegal}, 32'd1);
        step();
        we = 0;
        rd_chk("hartid_kept", 12'hF14, HART);

        // Interrupt synchronisation
        irq_t = 1;
        #1;
        chk("mtip_not_yet", {31'd0, mip_t}, 32'd0);
        step();
        chk("mtip_one_edge", {31'd0, mip_t}, 32'd1);
        rd_chk("mip_rd", 12'h344, 32'h80);
        irq_t = 0; irq_e = 1;
        step();
        irq_e = 0;
        chk("mip_level", outs(), 32'h04);

`ifdef CSR_COUNTERS_EN
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        rd_chk("mcycle_wr", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("mcycleh_pre", 12'hB80, 32'd0);
        step();
        rd_chk("mcycleh_carry", 12'hB80, 32'd1);
        rd_chk("mcycle_wrap", 12'hB00, 32'd0);
        csr_wr(12'hB02, 32'd5);
        instret = 1;
        repeat (3) step();
        instret = 0;
        step();
        rd_chk("minstret", 12'hB02, 32'd8);
        rd_chk("minstreth", 12'hB82, 32'd0);
`else
        rd_chk("mcycle_unimpl", 12'hB00, 32'd0);
        chk("mcycle_ill", {31'd0, illegal}, 32'd1);
        rd_chk("minstreth_unimpl", 12'hB82, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
